// File: rtl/tensor_cpu_core.sv
// rtl/tensor_cpu_core.sv - scalar ALU, CPU/tensor register files and a sequential single-MAC matrix engine
// Matrix multiply runs one MAC per cycle over bank0 x bank1 and writes the saturated result back into bank0.
module tensor_cpu_core #(
   parameter int DATA_WIDTH    = 8,
   parameter int CPU_REG_COUNT = 32,
   parameter int TENSOR_DIM    = 4
) (
   input  logic                                          clock_in,
   input  logic                                          reset_n_in,
   input  logic [31:0]                                   instruction_in,
   input  logic                                          instruction_valid_in,
   output logic                                          instruction_ready_out,
   output logic [DATA_WIDTH-1:0]                         cpu_output,
   output logic                                          cpu_output_valid_out,
   output logic                                          tensor_busy_out,
   output logic [4:0]                                    status_register_out,
   output logic [TENSOR_DIM*TENSOR_DIM*DATA_WIDTH-1:0]   tensor_core_result
);
   localparam int W    = DATA_WIDTH;
   localparam int W2   = 2 * DATA_WIDTH;
   localparam int N    = TENSOR_DIM;
   localparam int NN   = N * N;
   localparam int TE   = 2 * NN;
   localparam int AW   = $clog2(CPU_REG_COUNT);
   localparam int CW   = $clog2(TENSOR_DIM);
   localparam int ACCW = 2 * DATA_WIDTH + 2;

   localparam logic [7:0] OP_ADD = 8'h00, OP_SUB = 8'h01, OP_MUL = 8'h02, OP_EQL = 8'h03;
   localparam logic [7:0] OP_GRT = 8'h04, OP_OPERATE = 8'h05, OP_TLOAD = 8'h06, OP_CPU_TO_T = 8'h07;
   localparam logic [7:0] OP_ADDI = 8'h09, OP_SUBI = 8'h0A, OP_MOV = 8'h0B, OP_TMOV = 8'h0C;
   localparam logic [7:0] OP_SOFT_RESET = 8'h0D, OP_T_TO_CPU = 8'h0E, OP_READ_CPU = 8'h0F, OP_READ_T = 8'h10;

   localparam logic [ACCW-1:0] SAT_MAX = {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic [ACCW-1:0] SAT_MIN = {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_WRITEBACK} state_t;

   state_t            r_state, w_state_next;
   logic [W-1:0]      r_cpu_regs [CPU_REG_COUNT];
   logic [TE*W-1:0]   r_treg;
   logic [NN*W-1:0]   r_cbuf, r_result;
   logic [CW-1:0]     r_i, r_j, r_k;
   logic [ACCW-1:0]   r_acc;
   logic [W-1:0]      r_cpu_out;
   logic              r_out_valid;
   logic [4:0]        r_status;

   logic [7:0]        w_op;
   logic [AW-1:0]     w_rd, w_rs1, w_rs2;
   logic [4:0]        w_tdst, w_tsrc;
   logic              w_unused_bits;
   logic              w_accept, w_tdst_ok;
   logic [W-1:0]      w_a, w_b, w_imm, w_tsrc_val, w_alu_res, w_out_val, w_sat;
   logic [W:0]        w_wide;
   logic [W2-1:0]     w_prod, w_mac_prod;
   logic              w_alu_we, w_flag_we, w_carry, w_ovf, w_mac_last;
   logic [4:0]        w_flags;
   logic [ACCW-1:0]   w_acc_next;
   int                w_a_idx, w_b_idx, w_c_idx;

   assign w_op          = instruction_in[7:0];
   assign w_rd          = instruction_in[24 +: AW];
   assign w_rs1         = instruction_in[16 +: AW];
   assign w_rs2         = instruction_in[8 +: AW];
   assign w_tdst        = instruction_in[28:24];
   assign w_tsrc        = instruction_in[20:16];
   assign w_unused_bits = ^instruction_in[31:29];
   assign w_accept      = instruction_valid_in && (r_state == S_IDLE);
   assign w_tdst_ok     = int'(w_tdst) < TE;
   assign w_a           = r_cpu_regs[w_rs1];
   assign w_b           = r_cpu_regs[w_rs2];
   assign w_imm         = W'($signed(instruction_in[15:8]));

   always_comb begin
      w_tsrc_val = '0;
      if (int'(w_tsrc) < TE) w_tsrc_val = r_treg[int'(w_tsrc)*W +: W];
   end

   always_comb begin
      w_alu_res = '0;
      w_alu_we  = 1'b0;
      w_flag_we = 1'b0;
      w_carry   = 1'b0;
      w_ovf     = 1'b0;
      w_wide    = '0;
      w_prod    = '0;
      case (w_op)
         OP_ADD: begin
            w_wide    = {1'b0, w_a} + {1'b0, w_b};
            w_alu_res = w_wide[W-1:0];
            w_carry   = w_wide[W];
            w_ovf     = (w_a[W-1] == w_b[W-1]) && (w_alu_res[W-1] != w_a[W-1]);
         end
         OP_SUB: begin
            w_wide    = {1'b0, w_a} - {1'b0, w_b};
            w_alu_res = w_wide[W-1:0];
            w_carry   = w_wide[W];
            w_ovf     = (w_a[W-1] != w_b[W-1]) && (w_alu_res[W-1] != w_a[W-1]);
         end
         OP_MUL: begin
            w_prod    = W2'($signed(w_a)) * W2'($signed(w_b));
            w_alu_res = w_prod[W-1:0];
            // Product fits only if the top W+1 bits are all sign copies.
            w_ovf     = !((&w_prod[W2-1:W-1]) || !(|w_prod[W2-1:W-1]));
         end
         OP_EQL:      w_alu_res = {{(W-1){1'b0}}, (w_a == w_b)};
         OP_GRT:      w_alu_res = {{(W-1){1'b0}}, ($signed(w_a) > $signed(w_b))};
         OP_ADDI:     w_alu_res = w_a + w_imm;
         OP_SUBI:     w_alu_res = w_a - w_imm;
         OP_MOV:      w_alu_res = w_a;
         OP_T_TO_CPU: w_alu_res = w_tsrc_val;
         default:     w_alu_res = '0;
      endcase
      case (w_op)
         OP_ADD, OP_SUB, OP_MUL, OP_EQL, OP_GRT, OP_ADDI, OP_SUBI, OP_MOV, OP_T_TO_CPU: begin
            w_alu_we  = 1'b1;
            w_flag_we = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_flags = {^w_alu_res, w_ovf, w_carry, (w_alu_res == '0), w_alu_res[W-1]};

   always_comb begin
      case (w_op)
         OP_READ_CPU: w_out_val = w_a;
         OP_READ_T:   w_out_val = w_tsrc_val;
         default:     w_out_val = w_alu_res;
      endcase
   end

   always_comb begin
      w_a_idx    = int'(r_i) * N + int'(r_k);
      w_b_idx    = NN + int'(r_k) * N + int'(r_j);
      w_c_idx    = int'(r_i) * N + int'(r_j);
      w_mac_prod = W2'($signed(r_treg[w_a_idx*W +: W])) * W2'($signed(r_treg[w_b_idx*W +: W]));
      w_acc_next = ((r_k == '0) ? '0 : r_acc) + {{2{w_mac_prod[W2-1]}}, w_mac_prod};
      if ($signed(w_acc_next) > $signed(SAT_MAX))      w_sat = {1'b0, {(W-1){1'b1}}};
      else if ($signed(w_acc_next) < $signed(SAT_MIN)) w_sat = {1'b1, {(W-1){1'b0}}};
      else                                             w_sat = w_acc_next[W-1:0];
      w_mac_last = (r_i == CW'(N-1)) && (r_j == CW'(N-1)) && (r_k == CW'(N-1));
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:      if (w_accept && (w_op == OP_OPERATE)) w_state_next = S_COMPUTE;
         S_COMPUTE:   if (w_mac_last) w_state_next = S_WRITEBACK;
         S_WRITEBACK: w_state_next = S_IDLE;
         default:     w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_state     <= S_IDLE;
         for (int r = 0; r < CPU_REG_COUNT; r++) r_cpu_regs[r] <= '0;
         r_treg      <= '0;
         r_cbuf      <= '0;
         r_result    <= '0;
         r_i         <= '0;
         r_j         <= '0;
         r_k         <= '0;
         r_acc       <= '0;
         r_cpu_out   <= '0;
         r_out_valid <= 1'b0;
         r_status    <= '0;
      end else begin
         r_state     <= w_state_next;
         r_out_valid <= 1'b0;
         if (w_accept) begin
            r_cpu_out   <= w_out_val;
            r_out_valid <= (w_op != OP_OPERATE);
            if (w_alu_we)  r_cpu_regs[w_rd] <= w_alu_res;
            if (w_flag_we) r_status <= w_flags;
            case (w_op)
               OP_TLOAD:    if (w_tdst_ok) r_treg[int'(w_tdst)*W +: W] <= W'($signed(instruction_in[23:16]));
               OP_CPU_TO_T: if (w_tdst_ok) r_treg[int'(w_tdst)*W +: W] <= w_a;
               OP_TMOV:     if (w_tdst_ok) r_treg[int'(w_tdst)*W +: W] <= w_tsrc_val;
               OP_OPERATE: begin
                  r_i <= '0;
                  r_j <= '0;
                  r_k <= '0;
               end
               OP_SOFT_RESET: begin
                  for (int r = 0; r < CPU_REG_COUNT; r++) r_cpu_regs[r] <= '0;
                  r_treg   <= '0;
                  r_status <= '0;
               end
               default: ;
            endcase
         end
         if (r_state == S_COMPUTE) begin
            r_acc <= w_acc_next;
            if (r_k == CW'(N-1)) begin
               r_cbuf[w_c_idx*W +: W] <= w_sat;
               r_k <= '0;
               if (r_j == CW'(N-1)) begin
                  r_j <= '0;
                  r_i <= r_i + CW'(1);
               end else begin
                  r_j <= r_j + CW'(1);
               end
            end else begin
               r_k <= r_k + CW'(1);
            end
         end
         if (r_state == S_WRITEBACK) begin
            r_treg[NN*W-1:0] <= r_cbuf;
            r_result         <= r_cbuf;
         end
      end
   end

   assign instruction_ready_out = (r_state == S_IDLE);
   assign tensor_busy_out       = (r_state != S_IDLE);
   assign cpu_output            = r_cpu_out;
   assign cpu_output_valid_out  = r_out_valid;
   assign status_register_out   = r_status;
   assign tensor_core_result    = r_result;
endmodule

// File: tb/tb_tensor_cpu_core.sv
// tb/tb_tensor_cpu_core.sv - directed self-checking bench for tensor_cpu_core
module tb_tensor_cpu_core;
   localparam logic [7:0] OP_ADD = 8'h00, OP_SUB = 8'h01, OP_MUL = 8'h02, OP_EQL = 8'h03;
   localparam logic [7:0] OP_GRT = 8'h04, OP_OPERATE = 8'h05, OP_TLOAD = 8'h06, OP_CPU_TO_T = 8'h07;
   localparam logic [7:0] OP_NOP = 8'h08, OP_ADDI = 8'h09, OP_TMOV = 8'h0C;
   localparam logic [7:0] OP_SOFT_RESET = 8'h0D, OP_T_TO_CPU = 8'h0E, OP_READ_CPU = 8'h0F, OP_READ_T = 8'h10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [31:0]  ins_a, ins_b;
   logic         vld_a, vld_b;
   logic         rdy_a, ovld_a, busy_a, rdy_b, ovld_b, busy_b;
   logic [7:0]   cpu_a, cpu_b;
   logic [4:0]   st_a, st_b;
   logic [127:0] res_a;
   logic [31:0]  res_b;
   logic [127:0] exp_m;
   int           n_checks = 0;
   int           n_fail = 0;

   tensor_cpu_core #(.DATA_WIDTH(8), .CPU_REG_COUNT(32), .TENSOR_DIM(4)) dut (
      .clock_in(clk), .reset_n_in(rst_n), .instruction_in(ins_a), .instruction_valid_in(vld_a),
      .instruction_ready_out(rdy_a), .cpu_output(cpu_a), .cpu_output_valid_out(ovld_a),
      .tensor_busy_out(busy_a), .status_register_out(st_a), .tensor_core_result(res_a));

   tensor_cpu_core #(.DATA_WIDTH(8), .CPU_REG_COUNT(32), .TENSOR_DIM(2)) dut2 (
      .clock_in(clk), .reset_n_in(rst_n), .instruction_in(ins_b), .instruction_valid_in(vld_b),
      .instruction_ready_out(rdy_b), .cpu_output(cpu_b), .cpu_output_valid_out(ovld_b),
      .tensor_busy_out(busy_b), .status_register_out(st_b), .tensor_core_result(res_b));

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] rd,
                                      input logic [7:0] rs1, input logic [7:0] rs2);
      return {rd, rs1, rs2, op};
   endfunction

   task automatic send(input bit sel, input logic [31:0] ins);
      int t;
      t = 0;
      @(negedge clk);
      while (!(sel ? rdy_b : rdy_a) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) check_eq("send_ready_timeout", sel ? rdy_b : rdy_a, 1);
      if (sel) begin ins_b = ins; vld_b = 1'b1; end
      else     begin ins_a = ins; vld_a = 1'b1; end
      @(posedge clk);
      #1;
      vld_a = 1'b0;
      vld_b = 1'b0;
   endtask

   task automatic tload(input bit sel, input int addr, input logic [7:0] v);
      send(sel, mk(OP_TLOAD, 8'(addr), v, 8'h00));
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy_a && cyc < 300) begin
         cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int cyc, pulses, waits;
      rst_n = 1'b0; vld_a = 1'b0; vld_b = 1'b0; ins_a = '0; ins_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_cpu_out", cpu_a, 0);
      check_eq("rst_valid", ovld_a, 0);
      check_eq("rst_ready", rdy_a, 1);
      check_eq("rst_busy", busy_a, 0);
      check_eq("rst_status", st_a, 0);
      check_eq("rst_result", res_a, 0);
      @(negedge clk) rst_n = 1'b1;

      send(0, mk(OP_ADDI, 1, 0, 8'h7F));
      check_eq("addi_out", cpu_a, 8'h7F);
      check_eq("addi_valid", ovld_a, 1);
      send(0, mk(OP_ADDI, 2, 0, 8'h01));
      send(0, mk(OP_ADD, 3, 1, 2));
      check_eq("add_out", cpu_a, 8'h80);
      check_eq("add_status", st_a, 5'b11001);
      send(0, mk(OP_READ_CPU, 0, 3, 0));
      check_eq("read_r3", cpu_a, 8'h80);
      check_eq("read_status", st_a, 5'b11001);
      send(0, mk(OP_SUB, 4, 2, 2));
      check_eq("sub_zero_out", cpu_a, 8'h00);
      check_eq("sub_zero_status", st_a, 5'b00010);
      send(0, mk(OP_GRT, 5, 1, 2));
      check_eq("grt_out", cpu_a, 8'h01);
      check_eq("grt_status", st_a, 5'b10000);
      send(0, mk(OP_EQL, 6, 1, 2));
      check_eq("eql_out", cpu_a, 8'h00);
      send(0, mk(OP_MUL, 7, 1, 1));
      check_eq("mul_out", cpu_a, 8'h01);
      check_eq("mul_status", st_a, 5'b11000);
      send(0, mk(OP_SUB, 8, 2, 1));
      check_eq("sub_borrow_out", cpu_a, 8'h82);
      check_eq("sub_borrow_status", st_a, 5'b00101);
      send(0, mk(OP_ADDI, 9, 2, 8'hFD));
      check_eq("addi_neg_out", cpu_a, 8'hFE);
      check_eq("addi_neg_status", st_a, 5'b10001);
      send(0, mk(OP_NOP, 9, 2, 2));
      check_eq("nop_out", cpu_a, 8'h00);
      send(0, mk(8'h55, 9, 2, 2));
      check_eq("undef_valid", ovld_a, 1);
      check_eq("undef_status", st_a, 5'b10001);

      for (int a = 0; a < 16; a++) tload(0, a, (a / 4 == a % 4) ? 8'd1 : 8'd0);
      for (int a = 0; a < 16; a++) tload(0, 16 + a, 8'(a));
      send(0, mk(OP_OPERATE, 0, 0, 0));
      check_eq("op_busy", busy_a, 1);
      check_eq("op_not_ready", rdy_a, 0);
      check_eq("op_no_valid", ovld_a, 0);
      wait_idle(cyc);
      check_eq("op_cycles", cyc, 65);
      for (int e = 0; e < 16; e++) exp_m[e*8 +: 8] = 8'(e);
      check_eq("ident_result", res_a, exp_m);
      send(0, mk(OP_READ_T, 0, 5, 0));
      check_eq("read_t5", cpu_a, 8'd5);
      send(0, mk(OP_T_TO_CPU, 9, 21, 0));
      check_eq("t_to_cpu", cpu_a, 8'd5);
      check_eq("t_to_cpu_status", st_a, 5'b00000);

      send(0, mk(OP_OPERATE, 0, 0, 0));
      wait_idle(cyc);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            exp_m[(i*4+j)*8 +: 8] = (i == 0) ? 8'(56 + 6*j) : 8'd127;
      check_eq("bsq_result", res_a, exp_m);

      send(0, mk(OP_OPERATE, 0, 0, 0));
      @(negedge clk);
      ins_a = mk(OP_READ_CPU, 0, 3, 0);
      vld_a = 1'b1;
      pulses = 0;
      waits = 0;
      while (!rdy_a && waits < 300) begin
         if (ovld_a) pulses++;
         waits++;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      vld_a = 1'b0;
      check_eq("hold_wait", waits, 65);
      check_eq("hold_no_early_pulse", pulses, 0);
      check_eq("hold_valid", ovld_a, 1);
      check_eq("hold_out", cpu_a, 8'h80);
      @(posedge clk);
      #1;
      check_eq("hold_single_pulse", ovld_a, 0);

      send(0, mk(OP_CPU_TO_T, 0, 1, 0));
      send(0, mk(OP_READ_T, 0, 0, 0));
      check_eq("cpu_to_t", cpu_a, 8'h7F);
      send(0, mk(OP_TMOV, 1, 0, 0));
      send(0, mk(OP_READ_T, 0, 1, 0));
      check_eq("tmov", cpu_a, 8'h7F);

      for (int a = 0; a < 32; a++) tload(0, a, 8'd100);
      send(0, mk(OP_OPERATE, 0, 0, 0));
      wait_idle(cyc);
      for (int e = 0; e < 16; e++) exp_m[e*8 +: 8] = 8'h7F;
      check_eq("sat_pos", res_a, exp_m);
      for (int a = 0; a < 16; a++) tload(0, a, 8'h9C);
      send(0, mk(OP_OPERATE, 0, 0, 0));
      wait_idle(cyc);
      for (int e = 0; e < 16; e++) exp_m[e*8 +: 8] = 8'h80;
      check_eq("sat_neg", res_a, exp_m);

      send(0, mk(OP_SOFT_RESET, 0, 0, 0));
      check_eq("soft_rst_status", st_a, 0);
      send(0, mk(OP_READ_CPU, 0, 1, 0));
      check_eq("soft_rst_cpu", cpu_a, 0);
      send(0, mk(OP_READ_T, 0, 16, 0));
      check_eq("soft_rst_treg", cpu_a, 0);
      check_eq("soft_rst_keeps_result", res_a, exp_m);

      tload(1, 31, 8'h55);
      send(1, mk(OP_READ_T, 0, 31, 0));
      check_eq("n2_oob_read", cpu_b, 0);
      check_eq("n2_oob_valid", ovld_b, 1);
      tload(1, 7, 8'h55);
      send(1, mk(OP_READ_T, 0, 7, 0));
      check_eq("n2_last_addr", cpu_b, 8'h55);
      check_eq("n2_result", res_b, 0);
      check_eq("n2_busy", busy_b, 0);
      check_eq("n2_status", st_b, 0);

      send(0, mk(OP_OPERATE, 0, 0, 0));
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("abort_busy", busy_a, 0);
      check_eq("abort_ready", rdy_a, 1);
      check_eq("abort_result", res_a, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (80) @(posedge clk);
      #1;
      check_eq("abort_busy_after", busy_a, 0);
      check_eq("abort_result_after", res_a, 0);
      send(0, mk(OP_READ_T, 0, 0, 0));
      check_eq("abort_bank0", cpu_a, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/tensor_cpu_core.md
Name: tensor_cpu_core

Overview:
Parametrised successor to the single-cycle CPU/tensor-core block. It has a scalar ALU, a CPU register file and a two-bank tensor register file, with an instruction valid/ready handshake. The tensor matrix multiply is a multi-cycle, single-MAC sequential engine with saturating writeback, driven by one clock. It sits between the instruction sequencer and the top-level result outputs.

Parameters:
DATA_WIDTH, 8, signed scalar/element width (4..16)
CPU_REG_COUNT, 32, CPU registers (power of 2, <=256)
TENSOR_DIM, 4, matrix dimension N (2..4); tensor register file holds 2*N*N elements

Ports:
clock_in  in  1  clock, all state rising-edge
reset_n_in  in  1  asynchronous active-low reset
instruction_in  in  32  {rd/tdst[31:24], rs1/imm8/tsrc[23:16], rs2/imm[15:8], opcode[7:0]}
instruction_valid_in  in  1  instruction present
instruction_ready_out  out  1  core can accept; transfer = valid&&ready
cpu_output  out  DATA_WIDTH  registered read/ALU result (signed)
cpu_output_valid_out  out  1  one-cycle pulse, cpu_output updated
tensor_busy_out  out  1  matrix engine active
status_register_out  out  5  [4]parity [3]overflow [2]carry [1]zero [0]sign
tensor_core_result  out  N*N*DATA_WIDTH  last written-back matrix, element (i,j) at bits [(i*N+j)*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (async assert, sync release): all CPU/tensor registers, status, cpu_output, tensor_core_result, valid = 0. FSM=IDLE, ready=1. Reset during COMPUTE aborts with no writeback.
- Opcodes: ADD 00, SUB 01, MUL 02, EQL 03, GRT 04, OPERATE 05, TLOAD 06, CPU_TO_T 07, NOP 08, ADDI 09, SUBI 0A, MOV 0B, TMOV 0C, SOFT_RESET 0D, T_TO_CPU 0E, READ_CPU 0F, READ_T 10. Other opcodes behave as NOP.
- Register addresses: CPU uses the low clog2(CPU_REG_COUNT) bits of the field. Tensor addresses use bits [28:24] (dst) and [20:16] (src). Tensor address a maps to bank=a/(N*N), row=(a%(N*N))/N, col=a%N. Out-of-range writes are ignored; out-of-range reads return 0.
- Scalar ops complete at the accepting edge with no stall.
  - ADD/SUB/MUL write the low DATA_WIDTH bits. EQL writes 1 if equal, else 0. GRT writes 1 if rs1>rs2 (signed), else 0.
  - ADDI/SUBI: imm = instruction[15:8] truncated or sign-extended to DATA_WIDTH.
  - MOV: rd<=rs1. T_TO_CPU: rd<=treg[src].
- Flags update only on ADD..GRT, ADDI, SUBI, MOV and T_TO_CPU.
  - sign = result MSB; zero = result==0; parity = XOR of result bits.
  - ADD/SUB: carry = unsigned carry-out/borrow, overflow = signed overflow.
  - MUL: overflow = full product does not fit signed DATA_WIDTH, carry = 0.
  - Other ops: carry = overflow = 0.
- Tensor writes:
  - TLOAD: treg[dst] <= instruction[23:16] truncated or sign-extended.
  - CPU_TO_T: treg[dst] <= CPU rs1.
  - TMOV: treg[dst] <= treg[src].
- Reads: READ_CPU puts rs1 on cpu_output; READ_T puts treg[src]. All other accepted instructions put the ALU result (0 for non-ALU ops) on cpu_output.
  - cpu_output_valid_out pulses on the cycle after acceptance of any instruction except OPERATE.
- SOFT_RESET: clears both register files and status at the accepting edge; tensor_core_result is kept.
- Matrix FSM: IDLE -> COMPUTE -> WRITEBACK -> IDLE.
  - Accepting OPERATE enters COMPUTE. ready=0 and busy=1 from the next cycle.
  - COMPUTE: one MAC per cycle over k (inner), j, i, computing acc += A[i][k]*B[k][j], where A=bank0 and B=bank1. Accumulator is 2*DATA_WIDTH+2 bits signed, cleared at each k=0.
  - After k=N-1, the saturated result is stored in a C buffer (clamped to [-2^(W-1), 2^(W-1)-1]).
  - COMPUTE lasts N^3 cycles.
  - WRITEBACK (1 cycle): bank0 <= C, tensor_core_result <= C, bank1 unchanged.
  - busy drops and ready rises on the following cycle. Total OPERATE occupancy = N^3+1 cycles.
- While busy, instruction_valid_in is ignored (not accepted). instruction_in must be held stable by the sender until accepted.
- Back-to-back accepted scalar instructions see the previous result (write-before-read across edges; no forwarding needed within a cycle).

Test Plan:
- Reset -> all outputs 0, ready=1. Assert reset_n_in mid-COMPUTE -> busy=0 immediately, bank0 and tensor_core_result remain 0 after release.
- ADDI r1,r0,0x7F; ADDI r2,r0,1; ADD r3,r1,r2; READ_CPU r3 -> cpu_output=0x80, status overflow=1, sign=1, carry=0, parity=1.
- SUB r4,r2,r2 -> zero=1, carry=0; GRT r5,r1,r2 -> r5=1; EQL r6,r1,r2 -> r6=0; MUL r7,r1,r1 -> r7=0x01, overflow=1.
- N=4: bank0=identity, bank1[i][j]=i*4+j via TLOAD; OPERATE -> busy for 64 cycles plus 1 writeback, then tensor_core_result == bank1 and READ_T addr 5 = 5.
- All A,B elements = 100, OPERATE -> every C element saturates to 127; all = -100 with B=100 -> -128.
- Hold valid high with a READ_CPU during busy -> not accepted until ready=1, cpu_output_valid pulses exactly once. TLOAD addr 31 with N=2 -> ignored, READ_T 31 -> 0.
